// File: rtl/i2c_target_ctrl.sv
// rtl/i2c_target_ctrl.sv - I2C target controller with rx/tx first-word fall-through FIFOs
`timescale 1ns/1ps

module i2c_target_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o,
  output logic             full_o
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] PTR_ONE = 1;

  logic [PW:0]      wptr;
  logic [PW:0]      rptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty_o = (wptr == rptr);
  assign full_o  = (wptr[PW] != rptr[PW]) && (wptr[PW-1:0] == rptr[PW-1:0]);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = empty_o ? '0 : mem[rptr[PW-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + PTR_ONE;
      if (do_pop)  rptr <= rptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wptr[PW-1:0]] <= wdata_i;
  end
endmodule

module i2c_target_ctrl #(
  parameter int                    ADDR_WIDTH  = 7,
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    FIFO_DEPTH  = 4,
  parameter logic [ADDR_WIDTH-1:0] TARGET_ADDR = 7'h22
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  scl_i,
  input  logic                  sda_i,
  output logic                  sda_oe_o,
  output logic [DATA_WIDTH-1:0] rx_data_o,
  output logic                  rx_valid_o,
  input  logic                  rx_ready_i,
  input  logic [DATA_WIDTH-1:0] tx_data_i,
  input  logic                  tx_valid_i,
  output logic                  tx_ready_o,
  output logic                  busy_o,
  output logic                  op_o,
  output logic                  start_o,
  output logic                  stop_o,
  output logic                  rx_overflow_o,
  output logic                  tx_underflow_o
);
  localparam int SW = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int NB = (ADDR_WIDTH + 1 > DATA_WIDTH) ? ADDR_WIDTH + 1 : DATA_WIDTH;
  localparam int CW = $clog2(NB + 1);
  localparam logic [CW-1:0] ADDR_LAST = CW'(ADDR_WIDTH);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE
  } state_t;

  state_t          state;
  logic [CW-1:0]   bit_cnt;
  logic [SW-1:0]   shift;
  logic            ack_ok;
  logic            scl_s1, scl_s2, scl_q;
  logic            sda_s1, sda_s2, sda_q;
  logic            scl_rise, scl_fall, start_det, stop_det, bus_evt;
  logic            rx_push, rx_empty, rx_full;
  logic            tx_load, tx_empty, tx_full;
  logic [DATA_WIDTH-1:0] tx_head, tx_word;

  // Synchronizers idle high so reset release on an idle bus creates no edges.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      {scl_s1, scl_s2, scl_q} <= 3'b111;
      {sda_s1, sda_s2, sda_q} <= 3'b111;
    end else begin
      {scl_s1, scl_s2, scl_q} <= {scl_i, scl_s1, scl_s2};
      {sda_s1, sda_s2, sda_q} <= {sda_i, sda_s1, sda_s2};
    end
  end

  assign scl_rise  = scl_s2 && !scl_q;
  assign scl_fall  = !scl_s2 && scl_q;
  assign start_det = scl_s2 && scl_q && sda_q && !sda_s2;
  assign stop_det  = scl_s2 && scl_q && !sda_q && sda_s2;
  assign bus_evt   = start_det || stop_det;

  assign rx_push = scl_rise && !bus_evt && (state == WR_DATA) && (bit_cnt == DATA_LAST);
  assign tx_load = scl_rise && !bus_evt &&
                   (((state == ADDR_ACK) && op_o) || ((state == RD_ACK) && !sda_s2));
  assign tx_word = tx_empty ? '1 : tx_head;

  i2c_target_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (rx_push),
    .wdata_i ({shift[DATA_WIDTH-2:0], sda_s2}),
    .pop_i   (rx_ready_i),
    .rdata_o (rx_data_o),
    .empty_o (rx_empty),
    .full_o  (rx_full)
  );

  i2c_target_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (tx_valid_i),
    .wdata_i (tx_data_i),
    .pop_i   (tx_load),
    .rdata_o (tx_head),
    .empty_o (tx_empty),
    .full_o  (tx_full)
  );

  assign rx_valid_o = !rx_empty;
  assign tx_ready_o = !tx_full;

  // Bits are taken on SCL rise; sda_oe only moves on SCL fall (or bus events).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state          <= IDLE;
      bit_cnt        <= '0;
      shift          <= '0;
      ack_ok         <= 1'b0;
      sda_oe_o       <= 1'b0;
      busy_o         <= 1'b0;
      op_o           <= 1'b0;
      start_o        <= 1'b0;
      stop_o         <= 1'b0;
      rx_overflow_o  <= 1'b0;
      tx_underflow_o <= 1'b0;
    end else begin
      start_o        <= 1'b0;
      stop_o         <= 1'b0;
      rx_overflow_o  <= 1'b0;
      tx_underflow_o <= 1'b0;
      if (stop_det) begin
        state    <= IDLE;
        sda_oe_o <= 1'b0;
        busy_o   <= 1'b0;
        stop_o   <= 1'b1;
      end else if (start_det) begin
        state    <= ADDR;
        bit_cnt  <= '0;
        sda_oe_o <= 1'b0;
        start_o  <= 1'b1;
      end else if (scl_rise) begin
        case (state)
          ADDR: begin
            shift   <= {shift[SW-2:0], sda_s2};
            bit_cnt <= bit_cnt + CNT_ONE;
            if (bit_cnt == ADDR_LAST) begin
              if (shift[ADDR_WIDTH-1:0] == TARGET_ADDR) begin
                state  <= ADDR_ACK;
                op_o   <= sda_s2;
                busy_o <= 1'b1;
              end else begin
                state  <= IGNORE;
                busy_o <= 1'b0;
              end
            end
          end
          ADDR_ACK: begin
            bit_cnt <= '0;
            if (op_o) begin
              state          <= RD_DATA;
              shift          <= SW'(tx_word);
              tx_underflow_o <= tx_empty;
            end else begin
              state <= WR_DATA;
            end
          end
          WR_DATA: begin
            shift   <= {shift[SW-2:0], sda_s2};
            bit_cnt <= bit_cnt + CNT_ONE;
            if (bit_cnt == DATA_LAST) begin
              state         <= WR_ACK;
              ack_ok        <= !rx_full;
              rx_overflow_o <= rx_full;
            end
          end
          WR_ACK: begin
            state   <= WR_DATA;
            bit_cnt <= '0;
          end
          RD_DATA: begin
            shift   <= shift << 1;
            bit_cnt <= bit_cnt + CNT_ONE;
            if (bit_cnt == DATA_LAST) state <= RD_ACK;
          end
          RD_ACK: begin
            if (!sda_s2) begin
              state          <= RD_DATA;
              bit_cnt        <= '0;
              shift          <= SW'(tx_word);
              tx_underflow_o <= tx_empty;
            end else begin
              state  <= IGNORE;
              busy_o <= 1'b0;
            end
          end
          default: ;
        endcase
      end else if (scl_fall) begin
        case (state)
          ADDR_ACK: sda_oe_o <= 1'b1;
          WR_ACK:   sda_oe_o <= ack_ok;
          RD_DATA:  sda_oe_o <= !shift[DATA_WIDTH-1];
          default:  sda_oe_o <= 1'b0;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_i2c_target_ctrl.sv
// tb/tb_i2c_target_ctrl.sv - directed bench for i2c_target_ctrl
`timescale 1ns/1ps

module tb_i2c_target_ctrl;
  localparam int Q = 100;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_line;
  logic       sda_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       busy, op, start_p, stop_p, ovf_p, unf_p;

  int chk_cnt = 0;
  int pass_cnt = 0;
  int n_start = 0, n_stop = 0, n_ovf = 0, n_unf = 0, n_oe = 0, n_busy = 0;

  assign sda_line = sda_m & ~sda_oe;

  i2c_target_ctrl dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .scl_i          (scl_m),
    .sda_i          (sda_line),
    .sda_oe_o       (sda_oe),
    .rx_data_o      (rx_data),
    .rx_valid_o     (rx_valid),
    .rx_ready_i     (rx_ready),
    .tx_data_i      (tx_data),
    .tx_valid_i     (tx_valid),
    .tx_ready_o     (tx_ready),
    .busy_o         (busy),
    .op_o           (op),
    .start_o        (start_p),
    .stop_o         (stop_p),
    .rx_overflow_o  (ovf_p),
    .tx_underflow_o (unf_p)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (start_p) n_start <= n_start + 1;
    if (stop_p)  n_stop  <= n_stop + 1;
    if (ovf_p)   n_ovf   <= n_ovf + 1;
    if (unf_p)   n_unf   <= n_unf + 1;
    if (sda_oe)  n_oe    <= n_oe + 1;
    if (busy)    n_busy  <= n_busy + 1;
  end

  task automatic m_start();
    sda_m = 1'b1; #(Q);
    scl_m = 1'b1; #(Q);
    sda_m = 1'b0; #(Q);
    scl_m = 1'b0; #(Q);
  endtask

  task automatic m_stop();
    sda_m = 1'b0; #(Q);
    scl_m = 1'b1; #(Q);
    sda_m = 1'b1; #(Q);
  endtask

  task automatic m_bit(input logic b, output logic r);
    sda_m = b;    #(Q);
    scl_m = 1'b1; #(Q);
    r = sda_line; #(Q);
    scl_m = 1'b0; #(Q);
  endtask

  task automatic m_write(input logic [7:0] d, output logic nack);
    logic r;
    for (int i = 7; i >= 0; i--) m_bit(d[i], r);
    m_bit(1'b1, nack);
  endtask

  task automatic m_read(input logic ack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      m_bit(1'b1, r);
      d[i] = r;
    end
    m_bit(!ack, r);
  endtask

  task automatic rx_pop(output logic v, output logic [7:0] d);
    @(negedge clk);
    v = rx_valid;
    d = rx_data;
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic tx_push(input logic [7:0] d);
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic test_reset();
    #(20);
    chk_cnt++; if (sda_oe !== 1'b0) $display("FAIL rst_sda_oe: got %b want 0", sda_oe); else pass_cnt++;
    chk_cnt++; if (rx_valid !== 1'b0) $display("FAIL rst_rx_valid: got %b want 0", rx_valid); else pass_cnt++;
    chk_cnt++; if (tx_ready !== 1'b1) $display("FAIL rst_tx_ready: got %b want 1", tx_ready); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else pass_cnt++;
    chk_cnt++; if (op !== 1'b0) $display("FAIL rst_op: got %b want 0", op); else pass_cnt++;
    chk_cnt++; if (rx_data !== 8'h00) $display("FAIL rst_rx_data: got %h want 00", rx_data); else pass_cnt++;
    chk_cnt++;
    if ({start_p, stop_p, ovf_p, unf_p} !== 4'b0000)
      $display("FAIL rst_pulses: got %b want 0000", {start_p, stop_p, ovf_p, unf_p});
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    #(Q);
  endtask

  task automatic test_basic_write();
    logic [7:0] wb [3];
    logic nack, v;
    logic [7:0] d;
    int s0, p0;
    wb = '{8'hA5, 8'h3C, 8'hFF};
    s0 = n_start;
    p0 = n_stop;
    m_start();
    m_write(8'h44, nack);
    chk_cnt++; if (nack !== 1'b0) $display("FAIL bw_addr_ack: got nack=%b want 0", nack); else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      m_write(wb[i], nack);
      chk_cnt++; if (nack !== 1'b0) $display("FAIL bw_data_ack[%0d]: got nack=%b want 0", i, nack); else pass_cnt++;
    end
    chk_cnt++; if (op !== 1'b0) $display("FAIL bw_op: got %b want 0", op); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b1) $display("FAIL bw_busy_mid: got %b want 1", busy); else pass_cnt++;
    m_stop();
    #(Q);
    chk_cnt++; if (busy !== 1'b0) $display("FAIL bw_busy_end: got %b want 0", busy); else pass_cnt++;
    chk_cnt++; if (n_start - s0 != 1) $display("FAIL bw_start_cnt: got %0d want 1", n_start - s0); else pass_cnt++;
    chk_cnt++; if (n_stop - p0 != 1) $display("FAIL bw_stop_cnt: got %0d want 1", n_stop - p0); else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      rx_pop(v, d);
      chk_cnt++;
      if (v !== 1'b1 || d !== wb[i]) $display("FAIL bw_rx[%0d]: got v=%b d=%h want v=1 d=%h", i, v, d, wb[i]);
      else pass_cnt++;
    end
    chk_cnt++; if (rx_valid !== 1'b0) $display("FAIL bw_rx_empty: got %b want 0", rx_valid); else pass_cnt++;
  endtask

  task automatic test_addr_mismatch();
    logic nack;
    int oe0, b0;
    oe0 = n_oe;
    b0  = n_busy;
    m_start();
    m_write(8'h46, nack);
    chk_cnt++; if (nack !== 1'b1) $display("FAIL am_addr_nack: got nack=%b want 1", nack); else pass_cnt++;
    m_write(8'h5A, nack);
    chk_cnt++; if (nack !== 1'b1) $display("FAIL am_data_nack: got nack=%b want 1", nack); else pass_cnt++;
    m_stop();
    #(Q);
    chk_cnt++; if (n_oe != oe0) $display("FAIL am_sda_driven: got %0d cycles want 0", n_oe - oe0); else pass_cnt++;
    chk_cnt++; if (rx_valid !== 1'b0) $display("FAIL am_rx_valid: got %b want 0", rx_valid); else pass_cnt++;
    chk_cnt++; if (n_busy != b0) $display("FAIL am_busy: got %0d cycles want 0", n_busy - b0); else pass_cnt++;
  endtask

  task automatic test_read();
    logic nack;
    logic [7:0] d;
    tx_push(8'h81);
    tx_push(8'h42);
    m_start();
    m_write(8'h45, nack);
    chk_cnt++; if (nack !== 1'b0) $display("FAIL rd_addr_ack: got nack=%b want 0", nack); else pass_cnt++;
    chk_cnt++; if (op !== 1'b1) $display("FAIL rd_op: got %b want 1", op); else pass_cnt++;
    m_read(1'b1, d);
    chk_cnt++; if (d !== 8'h81) $display("FAIL rd_byte0: got %h want 81", d); else pass_cnt++;
    m_read(1'b0, d);
    chk_cnt++; if (d !== 8'h42) $display("FAIL rd_byte1: got %h want 42", d); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL rd_busy_after_nack: got %b want 0", busy); else pass_cnt++;
    m_stop();
    #(Q);
  endtask

  task automatic test_overflow_underflow();
    logic nack, v;
    logic [7:0] d;
    int o0, u0;
    o0 = n_ovf;
    m_start();
    m_write(8'h44, nack);
    chk_cnt++; if (nack !== 1'b0) $display("FAIL ov_addr_ack: got nack=%b want 0", nack); else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      m_write(8'h10 + 8'(i), nack);
      chk_cnt++;
      if (nack !== (i == 4)) $display("FAIL ov_ack[%0d]: got nack=%b want %b", i, nack, (i == 4));
      else pass_cnt++;
    end
    m_stop();
    #(Q);
    chk_cnt++; if (n_ovf - o0 != 1) $display("FAIL ov_pulses: got %0d want 1", n_ovf - o0); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      rx_pop(v, d);
      chk_cnt++;
      if (v !== 1'b1 || d !== 8'h10 + 8'(i)) $display("FAIL ov_rx[%0d]: got v=%b d=%h want v=1 d=%h", i, v, d, 8'h10 + 8'(i));
      else pass_cnt++;
    end
    chk_cnt++; if (rx_valid !== 1'b0) $display("FAIL ov_rx_empty: got %b want 0", rx_valid); else pass_cnt++;
    u0 = n_unf;
    m_start();
    m_write(8'h45, nack);
    chk_cnt++; if (nack !== 1'b0) $display("FAIL un_addr_ack: got nack=%b want 0", nack); else pass_cnt++;
    m_read(1'b0, d);
    chk_cnt++; if (d !== 8'hFF) $display("FAIL un_byte: got %h want ff", d); else pass_cnt++;
    m_stop();
    #(Q);
    chk_cnt++; if (n_unf - u0 != 1) $display("FAIL un_pulses: got %0d want 1", n_unf - u0); else pass_cnt++;
  endtask

  task automatic test_repeated_start();
    logic nack, v;
    logic [7:0] d;
    int s0;
    tx_push(8'h55);
    s0 = n_start;
    m_start();
    m_write(8'h44, nack);
    chk_cnt++; if (nack !== 1'b0) $display("FAIL rs_waddr_ack: got nack=%b want 0", nack); else pass_cnt++;
    m_write(8'h10, nack);
    chk_cnt++; if (nack !== 1'b0) $display("FAIL rs_data_ack: got nack=%b want 0", nack); else pass_cnt++;
    m_start();
    m_write(8'h45, nack);
    chk_cnt++; if (nack !== 1'b0) $display("FAIL rs_raddr_ack: got nack=%b want 0", nack); else pass_cnt++;
    m_read(1'b0, d);
    chk_cnt++; if (d !== 8'h55) $display("FAIL rs_read: got %h want 55", d); else pass_cnt++;
    chk_cnt++; if (op !== 1'b1) $display("FAIL rs_op: got %b want 1", op); else pass_cnt++;
    m_stop();
    #(Q);
    chk_cnt++; if (n_start - s0 != 2) $display("FAIL rs_start_cnt: got %0d want 2", n_start - s0); else pass_cnt++;
    rx_pop(v, d);
    chk_cnt++; if (v !== 1'b1 || d !== 8'h10) $display("FAIL rs_rx: got v=%b d=%h want v=1 d=10", v, d); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic nack, r, v;
    logic [7:0] d;
    tx_push(8'h00);
    m_start();
    m_write(8'h45, nack);
    chk_cnt++; if (nack !== 1'b0) $display("FAIL rm_addr_ack: got nack=%b want 0", nack); else pass_cnt++;
    for (int i = 0; i < 3; i++) m_bit(1'b1, r);
    sda_m = 1'b1; #(Q);
    scl_m = 1'b1; #(Q / 2);
    chk_cnt++; if (sda_oe !== 1'b1) $display("FAIL rm_driving: got %b want 1", sda_oe); else pass_cnt++;
    rst_n = 1'b0;
    #1;
    chk_cnt++; if (sda_oe !== 1'b0) $display("FAIL rm_async_release: got %b want 0", sda_oe); else pass_cnt++;
    #(Q / 2 - 1);
    scl_m = 1'b0; #(Q);
    m_stop();
    @(negedge clk);
    rst_n = 1'b1;
    #(Q);
    chk_cnt++; if (busy !== 1'b0 || rx_valid !== 1'b0) $display("FAIL rm_post_reset: got busy=%b rx_valid=%b want 0 0", busy, rx_valid); else pass_cnt++;
    m_start();
    m_write(8'h44, nack);
    chk_cnt++; if (nack !== 1'b0) $display("FAIL rm_addr2_ack: got nack=%b want 0", nack); else pass_cnt++;
    m_write(8'h99, nack);
    chk_cnt++; if (nack !== 1'b0) $display("FAIL rm_data_ack: got nack=%b want 0", nack); else pass_cnt++;
    m_stop();
    #(Q);
    rx_pop(v, d);
    chk_cnt++; if (v !== 1'b1 || d !== 8'h99) $display("FAIL rm_rx: got v=%b d=%h want v=1 d=99", v, d); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic_write();
    test_addr_mismatch();
    test_read();
    test_overflow_underflow();
    test_repeated_start();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
